// File: rtl/clk_en_seq.sv
// clk_en_seq: holds the core in reset until PLL lock is stable, then emits fractional clock enables.
// Define CLK_EN_PAUSE_EN to add a pause input that freezes the CPU and sound enables.
module clk_en_seq #(
    parameter int LOCK_HOLD = 1024,
    parameter int CPU_NUM   = 1,
    parameter int CPU_DEN   = 10,
    parameter int SND_NUM   = 1,
    parameter int SND_DEN   = 20,
    parameter int PIX_NUM   = 3,
    parameter int PIX_DEN   = 40
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic pll_locked,
`ifdef CLK_EN_PAUSE_EN
    input  logic pause,
`endif
    input  logic soft_rst,
    output logic core_reset,
    output logic running,
    output logic ce_cpu,
    output logic ce_snd,
    output logic ce_pix
);
    typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;
    localparam int CW = $clog2(LOCK_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(LOCK_HOLD - 1);
    localparam int NUM_A [3] = '{CPU_NUM, SND_NUM, PIX_NUM};
    localparam int DEN_A [3] = '{CPU_DEN, SND_DEN, PIX_DEN};

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_core_reset;
    logic          r_running;
    logic          w_lock_s;
    logic          w_abort;
    logic          w_run_nxt;
    logic          w_pause;
    logic [2:0]    w_ce;

    if (LOCK_HOLD < 1) begin : g_bad_hold
        $error("clk_en_seq: LOCK_HOLD must be at least 1");
    end

`ifdef CLK_EN_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_sync <= 2'b00;
        else          r_sync <= {r_sync[0], pll_locked};
    end

    assign w_lock_s = r_sync[1];
    // soft_rst wins over a rising lock, so it is folded into the same abort term
    assign w_abort  = !w_lock_s || soft_rst;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= WAIT_LOCK;
            r_cnt        <= '0;
            r_core_reset <= 1'b1;
            r_running    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= (w_next == HOLD && r_state == HOLD) ? r_cnt + CW'(1) : '0;
            r_core_reset <= !w_run_nxt;
            r_running    <= w_run_nxt;
        end
    end

    always_comb begin
        w_next = w_abort               ? WAIT_LOCK :
                 (r_state == WAIT_LOCK) ? HOLD :
                 (r_state == HOLD)      ? ((r_cnt == HOLD_LAST) ? RUN : HOLD) :
                 (r_state == RUN)       ? RUN : WAIT_LOCK;
    end

    always_comb begin
        w_run_nxt = (w_next == RUN);
    end

    assign core_reset = r_core_reset;
    assign running    = r_running;

    // Enables are gated on the next state so the first pulse lands on RUN index DEN/NUM-1
    for (genvar c = 0; c < 3; c++) begin : g_ch
        localparam int W = $clog2(DEN_A[c]) + 1;
        localparam logic [W-1:0] NUM_W = W'(NUM_A[c]);
        localparam logic [W-1:0] DEN_W = W'(DEN_A[c]);
        logic [W-1:0] r_acc;
        logic [W-1:0] w_sum;
        logic         w_wrap;
        logic         w_freeze;
        logic         r_ce;
        if (NUM_A[c] <= 0 || NUM_A[c] >= DEN_A[c]) begin : g_bad_ratio
            $error("clk_en_seq: channel %0d needs 0 < NUM < DEN", c);
        end
        assign w_sum    = r_acc + NUM_W;
        assign w_wrap   = (w_sum >= DEN_W);
        assign w_freeze = (c < 2) ? w_pause : 1'b0;
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                r_acc <= '0;
                r_ce  <= 1'b0;
            end else if (!w_run_nxt) begin
                r_acc <= '0;
                r_ce  <= 1'b0;
            end else if (w_freeze) begin
                r_ce  <= 1'b0;
            end else begin
                r_acc <= w_wrap ? w_sum - DEN_W : w_sum;
                r_ce  <= w_wrap;
            end
        end
        assign w_ce[c] = r_ce;
    end

    assign ce_cpu = w_ce[0];
    assign ce_snd = w_ce[1];
    assign ce_pix = w_ce[2];
endmodule

// File: doc/clk_en_seq.md
Name: clk_en_seq

Overview:
- Sits directly downstream of the system PLL; runs on the 80 MHz system clock and consumes the PLL lock indication.
- Holds the core in reset until lock has been stable for a programmable time.
- Afterwards generates single-cycle fractional clock enables for the 68000 CPU, the Z80 sound CPU and the pixel pipeline.
- Every other core block uses these enables and never uses derived clocks.

Parameters:
- LOCK_HOLD, 1024: clk_sys cycles that synced lock must stay high before release.
- CPU_NUM, 1: CPU enable numerator.
- CPU_DEN, 10: CPU enable denominator (80 MHz → 8 MHz).
- SND_NUM, 1: sound enable numerator.
- SND_DEN, 20: sound enable denominator (→ 4 MHz).
- PIX_NUM, 3: pixel enable numerator.
- PIX_DEN, 40: pixel enable denominator (→ 6 MHz).

Ports:
- clk_sys  in  1  80 MHz system clock
- reset_n  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL lock; asynchronous to clk_sys
- soft_rst  in  1  synchronous, level; forces a reset sequence
- core_reset  out  1  active-high core reset
- running  out  1  high in RUN state
- ce_cpu  out  1  CPU clock enable pulse
- ce_snd  out  1  sound CPU clock enable pulse
- ce_pix  out  1  pixel clock enable pulse

Behaviour:
- Reset (reset_n low, async):
  - Outputs: core_reset=1, running=0, all ce_*=0.
  - Internal: state=WAIT_LOCK, accumulators=0, hold counter=0, synchronizer flops=0.
- pll_locked passes through a 2-flop synchronizer → lock_s, giving 2 cycles of latency.
- WAIT_LOCK:
  - core_reset=1, counter=0.
  - Go to HOLD when lock_s=1 and soft_rst=0.
- HOLD:
  - Counter increments each cycle.
  - lock_s=0 or soft_rst=1 → WAIT_LOCK, counter cleared.
  - Counter reaches LOCK_HOLD-1 → RUN.
- RUN:
  - core_reset=0 and running=1, both registered and effective on the first RUN cycle.
  - lock_s=0 or soft_rst=1 → WAIT_LOCK. core_reset reasserts on the next edge; enables stop on that same edge.
- Enable generation, per channel X:
  - Accumulator acc_X has width clog2(DEN_X)+1.
  - In RUN each cycle: if acc_X+NUM_X >= DEN_X, then acc_X ← acc_X+NUM_X−DEN_X and ce_X ← 1; otherwise acc_X ← acc_X+NUM_X and ce_X ← 0.
  - ce_X is registered. At most one pulse per cycle. Exactly NUM_X pulses per DEN_X cycles, no drift.
  - Outside RUN: acc_X held at 0 and ce_X=0. The first pulse after release is deterministic.
  - With the defaults, the first ce_cpu occurs on the 10th RUN cycle (RUN cycle index 9, counting from 0), ce_snd on index 19, ce_pix on index 13.
- Legality:
  - 0 < NUM_X < DEN_X and LOCK_HOLD ≥ 1.
  - Violations stop elaboration via a generate-time check.
- Simultaneous events:
  - soft_rst has priority over lock_s rising.
  - reset_n low overrides everything asynchronously.
  - Lock glitches shorter than 2 cycles may be filtered by the synchronizer; any lock_s low during HOLD restarts the count.

Optional Feature:
- Macro CLK_EN_PAUSE_EN.
- When defined:
  - Adds input pause (1 bit, synchronous).
  - In RUN with pause=1: ce_cpu and ce_snd are forced to 0 and acc_cpu/acc_snd are frozen (not cleared).
  - ce_pix continues so video stays in sync.
  - On pause falling, the frozen channels resume exactly where they stopped.
  - pause has no effect outside RUN.
- When undefined: no pause port; behaviour exactly as above.

Test Plan:
- reset_n=0, pll_locked=1 → core_reset=1, ce_*=0. Release reset_n, keep locked → core_reset falls exactly 2+1+1024 cycles later (±1 per documented latency), running=1.
- In RUN over 400 cycles with defaults → exactly 40 ce_cpu, 20 ce_snd, 30 ce_pix. Pulses are single-cycle. ce_cpu spacing is exactly 10. ce_pix spacing follows the pattern 13/13/14.
- Drop pll_locked for 1 cycle in HOLD at count 500 → counter restarts. core_reset stays high for a full 1024 cycles after lock_s returns.
- Pulse soft_rst for 1 cycle in RUN → core_reset=1 and ce_*=0 on the next edge. The full HOLD repeats, and the first ce_cpu lands 10 cycles after re-release.
- Assert reset_n low mid-RUN, asynchronously between edges → core_reset=1 immediately without waiting for a clock edge. All accumulators=0.
- With CLK_EN_PAUSE_EN: pause for 37 cycles mid-RUN → no ce_cpu/ce_snd during the pause, ce_pix count unchanged. After the pause, cumulative ce_cpu count equals the unpaused reference shifted by 37 cycles.
